// File: rtl/div_ctrl_if.sv
// Divider-side bundle between the EXE-stage divide sequencer and the shared
// iterative divider: operands/mode/control in one direction, busy/result in the other.
interface div_ctrl_if;
  logic        div_start;
  logic        div_clr;
  logic        div_sign;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_busy;
  logic [63:0] div_result;

  modport master (
    output div_start, div_clr, div_sign, div_a, div_b,
    input  div_busy, div_result
  );

  modport slave (
    input  div_start, div_clr, div_sign, div_a, div_b,
    output div_busy, div_result
  );
endinterface

// File: rtl/div_ctrl.sv
// EXE-stage sequencer for the shared iterative divider: latches operands, stalls
// the pipeline while the divide runs, then issues a single HI/LO write.
module div_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_div_i,
  input  logic              is_signed_i,
  input  logic [31:0]       op_a_i,
  input  logic [31:0]       op_b_i,
  input  logic              flush_i,
  input  logic              ex_hold_i,
  div_ctrl_if.master        div,
  output logic              stall_req_o,
  output logic              hilo_we_o,
  output logic [31:0]       hi_out_o,
  output logic [31:0]       lo_out_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        div_a_q, div_a_d;
  logic [31:0]        div_b_q, div_b_d;
  logic               div_sign_q, div_sign_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               start_c;
  logic               clr_c;
  logic               stall_c;
  logic               we_c;
  logic               timeout_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      div_sign_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      div_sign_q <= div_sign_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    div_sign_d = div_sign_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    start_c    = 1'b0;
    clr_c      = 1'b0;
    stall_c    = 1'b0;
    we_c       = 1'b0;
    timeout_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (is_div_i && !flush_i) begin
          div_a_d    = op_a_i;
          div_b_d    = op_b_i;
          div_sign_d = is_signed_i;
          cnt_d      = '0;
          stall_c    = 1'b1;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        start_c = 1'b1;
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Busy drops only once the divider has seen start, so !busy here means done.
        if (flush_i) begin
          start_c = 1'b0;
          clr_c   = 1'b1;
          state_d = S_CLEAR;
        end else if (!div.div_busy) begin
          hi_d    = div.div_result[63:32];
          lo_d    = div.div_result[31:0];
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_d   = S_CLEAR;
        end
      end

      S_DONE: begin
        we_c = !ex_hold_i && !flush_i;
        if (flush_i) begin
          state_d = S_CLEAR;
        end else if (!ex_hold_i) begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: begin
        // Extra clear cycle so an aborted divide cannot leave the divider mid-sequence.
        clr_c   = 1'b1;
        stall_c = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign div.div_start = start_c;
  assign div.div_clr   = clr_c;
  assign div.div_sign  = div_sign_q;
  assign div.div_a     = div_a_q;
  assign div.div_b     = div_b_q;

  assign stall_req_o = stall_c;
  assign hilo_we_o   = we_c;
  assign hi_out_o    = hi_q;
  assign lo_out_o    = lo_q;
  assign timeout_o   = timeout_c;

endmodule
